hack_cpu_core: RTL

Hack CPU datapath and control that sits directly upstream of the 16-bit ALU.
- Decodes each 16-bit instruction and drives the ALU's six control bits and its x/y operands.
- Holds the A, D and PC registers and evaluates the jump condition from ALU status.
- Presents the memory-write interface to data RAM. One instruction executes per clock.

---
 rtl/hack_pkg.sv | 26 ++
 rtl/alu_basic.sv | 27 ++
 rtl/hack_cpu_core.sv | 86 ++++++++
 3 files changed

// File: rtl/hack_pkg.sv
// Shared definitions for the Hack CPU: word width, instruction field
// positions and the ALU comp encodings used most often.
package hack_pkg;

    localparam int WORD_W = 16;

    // Instruction field bit positions
    localparam int INSTR_C  = 15;
    localparam int INSTR_A  = 12;
    localparam int COMP_MSB = 11;
    localparam int COMP_LSB = 6;
    localparam int DEST_A   = 5;
    localparam int DEST_D   = 4;
    localparam int DEST_M   = 3;
    localparam int JMP_LT   = 2;
    localparam int JMP_EQ   = 1;
    localparam int JMP_GT   = 0;

    // Common comp encodings (zx,nx,zy,ny,f,no)
    localparam logic [5:0] COMP_ZERO   = 6'b101010;
    localparam logic [5:0] COMP_ONE    = 6'b111111;
    localparam logic [5:0] COMP_D      = 6'b001100;
    localparam logic [5:0] COMP_A      = 6'b110000;
    localparam logic [5:0] COMP_DPLUSA = 6'b000010;

endpackage

// File: rtl/alu_basic.sv
// Hack 16-bit ALU: optional zero/negate of each operand, add or AND,
// optional negate of the result. Purely combinational.
module alu_basic (
    input  logic [15:0] x,
    input  logic [15:0] y,
    input  logic        zx,
    input  logic        nx,
    input  logic        zy,
    input  logic        ny,
    input  logic        f,
    input  logic        no,
    output logic [15:0] out
);

    logic [15:0] x1, x2, y1, y2, r;

    // Operand conditioning, function select and output negate
    always_comb begin
        x1  = zx ? 16'h0000 : x;
        x2  = nx ? ~x1 : x1;
        y1  = zy ? 16'h0000 : y;
        y2  = ny ? ~y1 : y1;
        r   = f ? (x2 + y2) : (x2 & y2);
        out = no ? ~r : r;
    end

endmodule

// File: rtl/hack_cpu_core.sv
// Hack CPU datapath and control: decodes A/C instructions, drives the ALU,
// holds A, D and PC, resolves jumps and presents the RAM write port.
module hack_cpu_core
    import hack_pkg::*;
#(
    parameter int                     PC_WIDTH     = 15,
    parameter logic [PC_WIDTH-1:0]    RESET_VECTOR = '0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [WORD_W-1:0]   instruction,
    input  logic [WORD_W-1:0]   inM,
    output logic [WORD_W-1:0]   outM,
    output logic                writeM,
    output logic [PC_WIDTH-1:0] addressM,
    output logic [PC_WIDTH-1:0] pc
);

    logic [WORD_W-1:0]   a_q, a_d;
    logic [WORD_W-1:0]   d_q, d_d;
    logic [PC_WIDTH-1:0] pc_q, pc_d;

    logic              is_c;
    logic [5:0]        comp;
    logic [WORD_W-1:0] alu_y;
    logic [WORD_W-1:0] alu_out;
    logic              zr, ng, jump;
    logic              unused_bits;

    assign is_c  = instruction[INSTR_C];
    assign comp  = instruction[COMP_MSB:COMP_LSB];
    assign alu_y = instruction[INSTR_A] ? inM : a_q;

    alu_basic u_alu (
        .x   (d_q),
        .y   (alu_y),
        .zx  (comp[5]),
        .nx  (comp[4]),
        .zy  (comp[3]),
        .ny  (comp[2]),
        .f   (comp[1]),
        .no  (comp[0]),
        .out (alu_out)
    );

    assign zr = (alu_out == '0);
    assign ng = alu_out[WORD_W-1];

    // Bits 14:13 of a C-instruction and the upper A bits carry no meaning here
    assign unused_bits = ^{instruction[14:13], a_q};

    // Jump resolution and next-state selection for A, D and PC
    always_comb begin
        jump = is_c & ((instruction[JMP_LT] & ng) |
                       (instruction[JMP_EQ] & zr) |
                       (instruction[JMP_GT] & ~ng & ~zr));
        a_d  = a_q;
        d_d  = d_q;
        pc_d = jump ? a_q[PC_WIDTH-1:0] : pc_q + {{(PC_WIDTH-1){1'b0}}, 1'b1};
        if (!is_c) begin
            a_d = instruction;
        end else begin
            if (instruction[DEST_A]) a_d = alu_out;
            if (instruction[DEST_D]) d_d = alu_out;
        end
    end

    // State registers; reset discards the current instruction's effects
    always_ff @(posedge clk) begin
        if (reset) begin
            a_q  <= '0;
            d_q  <= '0;
            pc_q <= RESET_VECTOR;
        end else begin
            a_q  <= a_d;
            d_q  <= d_d;
            pc_q <= pc_d;
        end
    end

    assign outM     = alu_out;
    assign writeM   = is_c & instruction[DEST_M] & ~reset;
    assign addressM = a_q[PC_WIDTH-1:0];
    assign pc       = pc_q;

endmodule
